// File: rtl/prog_loader_ctrl.sv
// UART-driven program loader and run controller: receives 'L' count word payloads into
// instruction memory, and 'R'/'H'/'S' commands to run, halt and single-step the core.
module prog_loader_ctrl #(
  parameter int IMEM_ADDR_WIDTH = 10,
  parameter int NB_INSTRUCTION  = 32,
  parameter int NB_BYTE         = 8
) (
  input  logic                       clk,
  input  logic                       i_rst,
  input  logic [NB_BYTE-1:0]         i_rx_data,
  input  logic                       i_rx_valid,
  input  logic                       i_tx_busy,
  output logic [NB_BYTE-1:0]         o_tx_data,
  output logic                       o_tx_start,
  output logic                       o_imem_wen,
  output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
  output logic [NB_INSTRUCTION-1:0]  o_imem_data,
  output logic                       o_cpu_en,
  output logic                       o_cpu_rst,
  output logic                       o_busy
);

  localparam int BYTES_PER_WORD = NB_INSTRUCTION / NB_BYTE;
  localparam int BCNT_W         = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int IDX_W          = IMEM_ADDR_WIDTH - 2;
  localparam int CNT_W          = 2 * NB_BYTE;

  localparam logic [BCNT_W-1:0]  LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W:0]     ONE_EXT   = 1;
  localparam logic [CNT_W:0]     MAX_WORDS = ONE_EXT << IDX_W;

  localparam logic [NB_BYTE-1:0] CMD_LOAD = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'(8'h52);
  localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'(8'h53);
  localparam logic [NB_BYTE-1:0] CMD_HALT = NB_BYTE'(8'h48);
  localparam logic [NB_BYTE-1:0] ST_ACK_B = NB_BYTE'(8'h06);
  localparam logic [NB_BYTE-1:0] ST_NAK_B = NB_BYTE'(8'h15);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_LOAD,
    ST_ACK,
    ST_RUN,
    ST_STEP
  } state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [CNT_W-1:0]            word_idx_q, word_idx_d;
  logic [BCNT_W-1:0]           byte_cnt_q, byte_cnt_d;
  logic [NB_INSTRUCTION-1:0]   asm_q, asm_d;
  logic                        wen_q, wen_d;
  logic [IMEM_ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [NB_INSTRUCTION-1:0]   data_q, data_d;
  logic [NB_BYTE-1:0]          tx_data_q, tx_data_d;
  logic                        cpu_rst_q, cpu_rst_d;
  logic                        tx_start;

  logic [CNT_W-1:0]            full_count;
  logic [CNT_W-1:0]            idx_inc;
  logic                        final_pulse;
  logic                        loader_next;

  assign full_count  = {i_rx_data, count_q[NB_BYTE-1:0]};
  assign idx_inc     = word_idx_q + CNT_W'(1);
  // The write-pulse cycle of the last word is where the transfer is closed out.
  assign final_pulse = wen_q && (idx_inc == count_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    tx_data_d  = tx_data_q;
    tx_start   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_rx_valid) begin
          if (i_rx_data == CMD_LOAD)      state_d = ST_CNT_LO;
          else if (i_rx_data == CMD_RUN)  state_d = ST_RUN;
          else if (i_rx_data == CMD_STEP) state_d = ST_STEP;
        end
      end

      ST_CNT_LO: begin
        if (i_rx_valid) begin
          count_d[NB_BYTE-1:0] = i_rx_data;
          state_d              = ST_CNT_HI;
        end
      end

      ST_CNT_HI: begin
        if (i_rx_valid) begin
          count_d[CNT_W-1:NB_BYTE] = i_rx_data;
          word_idx_d               = '0;
          byte_cnt_d               = '0;
          if (full_count == '0) begin
            state_d   = ST_ACK;
            tx_data_d = ST_ACK_B;
          end else if ({1'b0, full_count} > MAX_WORDS) begin
            state_d   = ST_ACK;
            tx_data_d = ST_NAK_B;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (wen_q) begin
          word_idx_d = idx_inc;
        end
        if (final_pulse) begin
          state_d   = ST_ACK;
          tx_data_d = ST_ACK_B;
        end else if (i_rx_valid) begin
          // Bytes arrive least-significant first.
          asm_d[byte_cnt_q*NB_BYTE +: NB_BYTE] = i_rx_data;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            wen_d      = 1'b1;
            data_d     = asm_d;
            addr_d     = {word_idx_q[IDX_W-1:0], 2'b00};
          end else begin
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
          end
        end
      end

      ST_ACK: begin
        if (!i_tx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (i_rx_valid && (i_rx_data == CMD_HALT)) begin
          state_d = ST_IDLE;
        end
      end

      ST_STEP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Core stays in reset through the whole load and one extra cycle after the ACK leaves.
  assign loader_next = (state_d == ST_CNT_LO) || (state_d == ST_CNT_HI) ||
                       (state_d == ST_LOAD)   || (state_d == ST_ACK);
  assign cpu_rst_d   = !loader_next && (state_q != ST_ACK);

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      tx_data_q  <= '0;
      cpu_rst_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tx_data_q  <= tx_data_d;
      cpu_rst_q  <= cpu_rst_d;
    end
  end

  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start;
  assign o_imem_wen  = wen_q;
  assign o_imem_addr = addr_q;
  assign o_imem_data = data_q;
  assign o_cpu_en    = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign o_cpu_rst   = cpu_rst_q;
  assign o_busy      = (state_q != ST_IDLE) && (state_q != ST_RUN);

endmodule

// File: doc/prog_loader_ctrl.md
PROG_LOADER_CTRL -- requirements
Module: prog_loader_ctrl

Interface
REQ-001 Parameter IMEM_ADDR_WIDTH, default 10: byte-address width of instruction memory.
REQ-002 Parameter NB_INSTRUCTION, default 32: instruction word width.
REQ-003 Parameter NB_BYTE, default 8: UART byte width.
REQ-004 clk  in  1: single clock; all state changes on rising edge.
REQ-005 i_rst  in  1: reset, asynchronous, active-low.
REQ-006 i_rx_data  in  8: received UART byte.
REQ-007 i_rx_valid  in  1: one-cycle pulse; i_rx_data valid.
REQ-008 i_tx_busy  in  1: UART transmitter busy.
REQ-009 o_tx_data  out  8: byte to transmit.
REQ-010 o_tx_start  out  1: one-cycle transmit request.
REQ-011 o_imem_wen  out  1: instruction-memory write enable, one-cycle pulse per word.
REQ-012 o_imem_addr  out  IMEM_ADDR_WIDTH: write byte address.
REQ-013 o_imem_data  out  NB_INSTRUCTION: write word.
REQ-014 o_cpu_en  out  1: enables PC, IF/ID and ID/EX registers.
REQ-015 o_cpu_rst  out  1: active-low reset to core pipeline.
REQ-016 o_busy  out  1: high in any state other than IDLE and RUN.

Function
REQ-017 FSM states SHALL be IDLE, CNT_LO, CNT_HI, LOAD, ACK, RUN, STEP.
REQ-018 IDLE: byte 0x4C ('L') -> CNT_LO; 0x52 ('R') -> RUN; 0x53 ('S') -> STEP; all other bytes ignored.
REQ-019 CNT_LO captures count[7:0]; CNT_HI captures count[15:8], clears word index and byte counter.
REQ-020 After CNT_HI: count 0 -> ACK with 0x06; count > 2^(IMEM_ADDR_WIDTH-2) -> ACK with 0x15 (NAK), no writes; otherwise -> LOAD.
REQ-021 LOAD: bytes assembled little-endian (first byte -> bits [7:0]).
REQ-022 On the 4th byte of a word, o_imem_wen SHALL pulse high exactly one cycle later, with o_imem_data = assembled word and o_imem_addr = word_index*4 (low 2 bits zero).
REQ-023 Word index increments after each write; when index reaches count -> ACK with 0x06 in the same cycle as the final write pulse.
REQ-024 An i_rx_valid arriving in the write-pulse cycle SHALL be accepted as the next word's byte 0; no byte is dropped.
REQ-025 ACK: wait while i_tx_busy=1; when i_tx_busy=0, pulse o_tx_start one cycle with o_tx_data = status byte, then -> IDLE.
REQ-026 o_cpu_rst SHALL be 0 in CNT_LO, CNT_HI, LOAD and ACK, and for one cycle after ACK exits; 1 otherwise.
REQ-027 RUN: o_cpu_en=1; byte 0x48 ('H') -> IDLE with o_cpu_en=0 the following cycle; other bytes ignored.
REQ-028 STEP: o_cpu_en=1 for exactly one cycle, then -> IDLE.
REQ-029 o_cpu_en SHALL be 0 in every state except RUN and STEP.
REQ-030 o_tx_start and o_imem_wen SHALL never be high outside ACK and LOAD respectively.

Reset
REQ-031 On i_rst=0, immediately: state IDLE, o_cpu_en=0, o_cpu_rst=0, o_imem_wen=0, o_tx_start=0, o_tx_data=0, o_imem_addr=0, o_imem_data=0, counters 0, o_busy=0.
REQ-032 o_cpu_rst SHALL return to 1 on the first clock edge after i_rst deasserts.
REQ-033 Reset mid-LOAD aborts the transfer; partial word is discarded, no write pulse issued.

Verification
REQ-034 Load: 4C 02 00 13 00 00 00 93 00 10 00 -> writes 0x00000013@0x000 and 0x00100093@0x004, then o_tx_start with 0x06; o_cpu_rst low throughout.
REQ-035 Zero count: 4C 00 00 -> no o_imem_wen, 0x06 transmitted; oversize: 4C 01 01 -> no writes, 0x15 transmitted.
REQ-036 ACK backpressure: i_tx_busy held 1 for 20 cycles at ACK -> o_tx_start pulses exactly once, first cycle after busy drops.
REQ-037 Run/halt/step: 52 -> o_cpu_en=1 continuously, 'L' ignored; 48 -> o_cpu_en=0; 53 -> o_cpu_en high exactly one cycle.
REQ-038 Back-to-back: i_rx_valid in the write-pulse cycle of word 0 -> byte lands in word 1 bits [7:0].
REQ-039 Async reset after 6 of 8 data bytes -> outputs at reset values within the same cycle; a subsequent 'L' load works normally.
